// File: rtl/wb_initiator.sv
// Wishbone classic initiator: accepts one command at a time, runs a single
// CYC/STB bus cycle, and returns read data or error/timeout status.
// Optional feature: define WB_INITIATOR_TIMEOUT_EN to abort bus cycles that
// see no ACK/ERR within TIMEOUT_CYCLES cycles. Without the macro the
// initiator waits in the bus cycle indefinitely and rsp_tmo is tied low.
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        WB_CLK,
  input  logic        WB_RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [16:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_wdat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdat,
  output logic        rsp_err,
  output logic        rsp_tmo,
  output logic [16:0] WBs_ADR,
  output logic        WBs_CYC,
  output logic        WBs_STB,
  output logic        WBs_WE,
  output logic [3:0]  WBs_BYTE_STB,
  output logic [31:0] WBs_WR_DAT,
  input  logic [31:0] WBs_RD_DAT,
  input  logic        WBs_ACK,
  input  logic        WBs_ERR
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state;

  // Reject out-of-range timeout configurations at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT_CYCLES must be in 2..65535");
  end

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
`else
  assign rsp_tmo = 1'b0;
`endif

  // Handshake readiness is a pure decode of the registered state.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state        <= IDLE;
      WBs_ADR      <= '0;
      WBs_CYC      <= 1'b0;
      WBs_STB      <= 1'b0;
      WBs_WE       <= 1'b0;
      WBs_BYTE_STB <= '0;
      WBs_WR_DAT   <= '0;
      rsp_rdat     <= '0;
      rsp_err      <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      rsp_tmo      <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            WBs_ADR      <= cmd_adr;
            WBs_WE       <= cmd_we;
            WBs_BYTE_STB <= cmd_sel;
            WBs_WR_DAT   <= cmd_wdat;
            WBs_CYC      <= 1'b1;
            WBs_STB      <= 1'b1;
            state        <= BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        BUS: begin
          // ERR dominates a simultaneous ACK; data is kept only for clean reads.
          if (WBs_ACK || WBs_ERR) begin
            WBs_CYC  <= 1'b0;
            WBs_STB  <= 1'b0;
            rsp_err  <= WBs_ERR;
            rsp_rdat <= (!WBs_ERR && !WBs_WE) ? WBs_RD_DAT : 32'h0;
            state    <= RESP;
          end
`ifdef WB_INITIATOR_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            WBs_CYC  <= 1'b0;
            WBs_STB  <= 1'b0;
            rsp_tmo  <= 1'b1;
            rsp_rdat <= '0;
            state    <= RESP;
          end else begin
            tmo_cnt  <= tmo_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdat <= '0;
            rsp_err  <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            rsp_tmo  <= 1'b0;
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator with a randomized Wishbone responder.
module tb_wb_initiator;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic        rsp_tmo;
  logic [16:0] wb_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdat;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_err;

  int checks = 0;
  int failures = 0;

  wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .WB_CLK(clk), .WB_RST_N(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_wdat(cmd_wdat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .WBs_ADR(wb_adr), .WBs_CYC(wb_cyc), .WBs_STB(wb_stb), .WBs_WE(wb_we),
    .WBs_BYTE_STB(wb_sel), .WBs_WR_DAT(wb_wdat),
    .WBs_RD_DAT(wb_rdat), .WBs_ACK(wb_ack), .WBs_ERR(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One command through the bus; checks hold, response and release against the model.
  task automatic run_txn(input string name, input logic we, input logic [16:0] adr,
                         input logic [3:0] sel, input logic [31:0] wdat, input int waits,
                         input logic ack, input logic err, input logic [31:0] rdat,
                         input int stall, input bit noise);
    logic [55:0] exp_bus;
    logic [55:0] got_bus;
    logic [31:0] exp_rdat;
    exp_bus  = {1'b1, 1'b1, we, sel, adr, wdat};
    exp_rdat = (ack && !err && !we) ? rdat : 32'h0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_wdat = wdat;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = 17'($urandom);
    cmd_sel = 4'($urandom); cmd_wdat = $urandom;
    for (int i = 0; i <= waits; i++) begin
      got_bus = {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_wdat};
      checks++;
      if (got_bus !== exp_bus || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s bus_hold cycle %0d: got bus=%h rsp_valid=%b cmd_ready=%b, want bus=%h rsp_valid=0 cmd_ready=0",
                 name, i, got_bus, rsp_valid, cmd_ready, exp_bus);
      end
      if (i == waits) begin
        wb_ack = ack; wb_err = err; wb_rdat = rdat;
      end else begin
        wb_rdat = $urandom;
      end
      @(negedge clk);
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = $urandom;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdat !== exp_rdat ||
        rsp_err !== err || rsp_tmo !== 1'b0) begin
      failures++;
      $display("FAIL %s response: got cyc=%b stb=%b valid=%b rdat=%h err=%b tmo=%b, want cyc=0 stb=0 valid=1 rdat=%h err=%b tmo=0",
               name, wb_cyc, wb_stb, rsp_valid, rsp_rdat, rsp_err, rsp_tmo, exp_rdat, err);
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        cmd_valid = 1'($urandom); wb_ack = 1'($urandom); wb_err = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0 ||
          rsp_rdat !== exp_rdat || rsp_err !== err) begin
        failures++;
        $display("FAIL %s resp_stall cycle %0d: got valid=%b ready=%b cyc=%b rdat=%h err=%b, want valid=1 ready=0 cyc=0 rdat=%h err=%b",
                 name, i, rsp_valid, cmd_ready, wb_cyc, rsp_rdat, rsp_err, exp_rdat, err);
      end
    end
    cmd_valid = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_err !== 1'b0 || rsp_tmo !== 1'b0 ||
        wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL %s release: got valid=%b ready=%b err=%b tmo=%b cyc=%b, want 0 1 0 0 0",
               name, rsp_valid, cmd_ready, rsp_err, rsp_tmo, wb_cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
    cmd_wdat = '0; rsp_ready = 1'b0; wb_rdat = '0; wb_ack = 1'b0; wb_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_tmo !== 1'b0 || rsp_rdat !== 32'h0 || wb_adr !== 17'h0 || wb_we !== 1'b0 ||
        wb_sel !== 4'h0 || wb_wdat !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b valid=%b err=%b tmo=%b rdat=%h adr=%h we=%b sel=%h wdat=%h, want all 0",
               wb_cyc, wb_stb, rsp_valid, rsp_err, rsp_tmo, rsp_rdat, wb_adr, wb_we, wb_sel, wb_wdat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read_first_cycle();
    run_txn("read_ack_first", 1'b0, 17'h00010, 4'hF, 32'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_write_wait();
    run_txn("write_wait5", 1'b1, 17'h1FFFC, 4'h3, 32'h12345678, 5, 1'b1, 1'b0, 32'hCAFEF00D, 1, 1'b0);
  endtask

  task automatic test_ack_err_together();
    run_txn("read_ack_err", 1'b0, 17'h00444, 4'hF, 32'h0, 1, 1'b1, 1'b1, 32'hA5A5A5A5, 0, 1'b0);
  endtask

  task automatic test_resp_stall();
    run_txn("resp_stall_noise", 1'b0, 17'h00123, 4'hC, 32'h0, 2, 1'b1, 1'b0, 32'h13572468, 10, 1'b1);
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_stall_no_accept: got cyc=%b cmd_ready=%b, want 0 1", wb_cyc, cmd_ready);
    end
  endtask

  task automatic test_random();
    logic ack;
    logic err;
    int kind;
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 2));
      ack = (kind != 1);
      err = (kind != 0);
      run_txn($sformatf("random_%0d", n), 1'($urandom), 17'($urandom), 4'($urandom),
              $urandom, int'($urandom_range(0, 4)), ack, err, $urandom,
              int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  // Abort an in-flight bus cycle with reset on its third cycle.
  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h0BEEF; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || wb_adr !== 17'h0) begin
      failures++;
      $display("FAIL reset_mid_bus: got cyc=%b stb=%b valid=%b adr=%h, want 0 0 0 0",
               wb_cyc, wb_stb, rsp_valid, wb_adr);
    end
    wb_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_bus_after: got valid=%b cyc=%b ready=%b err=%b, want 0 0 1 0",
               rsp_valid, wb_cyc, cmd_ready, rsp_err);
    end
    run_txn("after_reset", 1'b0, 17'h00020, 4'h5, 32'h0, 1, 1'b1, 1'b0, 32'h89ABCDEF, 0, 1'b0);
  endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00300; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; wb_rdat = 32'hFFFFFFFF;
    n = 0;
    while (wb_cyc === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 8 || rsp_valid !== 1'b1 || rsp_tmo !== 1'b1 || rsp_err !== 1'b0 || rsp_rdat !== 32'h0) begin
      failures++;
      $display("FAIL timeout: got cyc_cycles=%0d valid=%b tmo=%b err=%b rdat=%h, want 8 1 1 0 0",
               n, rsp_valid, rsp_tmo, rsp_err, rsp_rdat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_tmo !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_release: got tmo=%b valid=%b ready=%b, want 0 0 1", rsp_tmo, rsp_valid, cmd_ready);
    end
    // ACK on the last allowed cycle wins over the timeout.
    run_txn("ack_at_timeout_edge", 1'b0, 17'h00304, 4'hF, 32'h0, 7, 1'b1, 1'b0, 32'h0BADF00D, 0, 1'b0);
  endtask
`else
  task automatic test_timeout();
    int n;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 17'h00300; cmd_sel = 4'hF; cmd_wdat = 32'h55AA55AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (wb_cyc === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 1000 || wb_cyc !== 1'b1 || rsp_valid !== 1'b0 || rsp_tmo !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout: got cyc_cycles=%0d cyc=%b valid=%b tmo=%b, want 1000 1 0 0",
               n, wb_cyc, rsp_valid, rsp_tmo);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_recover: got cyc=%b ready=%b valid=%b, want 0 1 0", wb_cyc, cmd_ready, rsp_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_first_cycle();
    test_write_wait();
    test_ack_err_together();
    test_resp_stall();
    test_random();
    test_timeout();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
